// File: rtl/mem_initiator.sv
// Load/store initiator: byte-addressed core requests to a ready/valid word memory, lane steering + split.
// Latency: aligned store resp 2 cycles after accept, aligned load 3; split adds 1 (store) / 2 (load).
// Backpressure: o_req_ready only in IDLE; mem phases hold addr/data/BE until wr_ready / rd_valid.
//
// Ports:
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_req_*/o_req_ready       core request (addr, write, size, unsigned, wdata)
//   o_resp_valid/o_resp_rdata one-cycle completion pulse, extended load data (0 for stores)
//   o_mem_*/i_mem_*           word-memory side: write valid/ready, read ready/valid, data, BE
module mem_initiator #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [31:0]           i_req_addr,
  input  logic                  i_req_write,
  input  logic [1:0]            i_req_size,
  input  logic                  i_req_unsigned,
  input  logic [31:0]           i_req_wdata,
  output logic                  o_resp_valid,
  output logic [31:0]           o_resp_rdata,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_data,
  output logic [3:0]            o_mem_byte_write_enable,
  output logic                  o_mem_wr_valid,
  input  logic                  i_mem_wr_ready,
  output logic                  o_mem_rd_ready,
  input  logic                  i_mem_rd_valid,
  input  logic [DATA_WIDTH-1:0] i_mem_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR0, S_WR1, S_RD0, S_RD1, S_RESP
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] word_q, word_d;
  logic [1:0]            off_q, off_d;
  logic [1:0]            size_q, size_d;
  logic                  uns_q, uns_d;
  logic [7:0]            mask_q, mask_d;
  logic [63:0]           wd_q, wd_d;
  logic [31:0]           lo_q, lo_d;
  logic [31:0]           rdata_q, rdata_d;

  // Upper address bits are intentionally ignored (memory is smaller than the core space).
  logic unused_addr_hi;
  assign unused_addr_hi = ^i_req_addr[31:ADDR_WIDTH+2];

  logic                  split;
  logic [ADDR_WIDTH-1:0] word_p1;
  assign split   = |mask_q[7:4];
  assign word_p1 = word_q + ADDR_WIDTH'(1);

  // Request decode: 8-lane mask over two consecutive words, lane-steered store data.
  logic [1:0]  req_size;
  logic [3:0]  req_nmask;
  logic [7:0]  req_mask;
  logic [63:0] req_shift;
  logic [63:0] req_wd;

  always_comb begin
    req_size  = (i_req_size == 2'd3) ? 2'd2 : i_req_size;
    case (req_size)
      2'd0:    req_nmask = 4'b0001;
      2'd1:    req_nmask = 4'b0011;
      default: req_nmask = 4'b1111;
    endcase
    req_mask  = {4'b0000, req_nmask} << i_req_addr[1:0];
    req_shift = {32'b0, i_req_wdata} << {i_req_addr[1:0], 3'b000};
    // Lanes outside the access drive zero even if the core left junk in upper wdata bits.
    for (int b = 0; b < 8; b++) begin
      req_wd[8*b +: 8] = req_mask[b] ? req_shift[8*b +: 8] : 8'h00;
    end
  end

  // Load merge: the final read beat is combined with the captured low word (if split).
  logic [63:0] merge_src;
  logic [63:0] merge_sh;
  logic [31:0] merge_r;
  logic [31:0] load_val;

  always_comb begin
    merge_src = (state_q == S_RD1) ? {i_mem_data, lo_q} : {32'b0, i_mem_data};
    merge_sh  = merge_src >> {off_q, 3'b000};
    merge_r   = merge_sh[31:0];
    case (size_q)
      2'd0:    load_val = {{24{~uns_q & merge_r[7]}}, merge_r[7:0]};
      2'd1:    load_val = {{16{~uns_q & merge_r[15]}}, merge_r[15:0]};
      default: load_val = merge_r;
    endcase
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    off_d   = off_q;
    size_d  = size_q;
    uns_d   = uns_q;
    mask_d  = mask_q;
    wd_d    = wd_q;
    lo_d    = lo_q;
    rdata_d = rdata_q;

    o_req_ready             = 1'b0;
    o_resp_valid            = 1'b0;
    o_mem_addr              = '0;
    o_mem_data              = '0;
    o_mem_byte_write_enable = 4'b0000;
    o_mem_wr_valid          = 1'b0;
    o_mem_rd_ready          = 1'b0;

    case (state_q)
      S_IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) begin
          word_d  = i_req_addr[ADDR_WIDTH+1:2];
          off_d   = i_req_addr[1:0];
          size_d  = req_size;
          uns_d   = i_req_unsigned;
          mask_d  = req_mask;
          wd_d    = req_wd;
          state_d = i_req_write ? S_WR0 : S_RD0;
        end
      end
      S_WR0: begin
        o_mem_wr_valid          = 1'b1;
        o_mem_addr              = word_q;
        o_mem_data              = wd_q[31:0];
        o_mem_byte_write_enable = mask_q[3:0];
        if (i_mem_wr_ready) begin
          state_d = split ? S_WR1 : S_RESP;
          rdata_d = '0;
        end
      end
      S_WR1: begin
        o_mem_wr_valid          = 1'b1;
        o_mem_addr              = word_p1;
        o_mem_data              = wd_q[63:32];
        o_mem_byte_write_enable = mask_q[7:4];
        if (i_mem_wr_ready) begin
          state_d = S_RESP;
          rdata_d = '0;
        end
      end
      S_RD0: begin
        o_mem_rd_ready = 1'b1;
        o_mem_addr     = word_q;
        if (i_mem_rd_valid) begin
          if (split) begin
            lo_d    = i_mem_data;
            state_d = S_RD1;
          end else begin
            rdata_d = load_val;
            state_d = S_RESP;
          end
        end
      end
      S_RD1: begin
        o_mem_rd_ready = 1'b1;
        o_mem_addr     = word_p1;
        if (i_mem_rd_valid) begin
          rdata_d = load_val;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        o_resp_valid = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_resp_rdata = rdata_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      off_q   <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      mask_q  <= '0;
      wd_q    <= '0;
      lo_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      off_q   <= off_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      mask_q  <= mask_d;
      wd_q    <= wd_d;
      lo_q    <= lo_d;
      rdata_q <= rdata_d;
    end
  end

endmodule
